// File: rtl/ex_muldiv_unit_pkg.sv
// Shared funct codes, FSM state encoding and decode helpers for the EX-stage mul/div unit.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_long_op(input logic [5:0] func);
    return (func == FN_MULT) || (func == FN_MULTU) || (func == FN_DIV) || (func == FN_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] func);
    return (func == FN_MULT) || (func == FN_DIV);
  endfunction

  function automatic logic is_div_op(input logic [5:0] func);
    return (func == FN_DIV) || (func == FN_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side request and HI/LO result signals of the mul/div unit.
interface muldiv_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mf_data;

  modport master (output start, func, op_a, op_b, flush,
                  input  stall, done, hi, lo, mf_data);
  modport slave  (input  start, func, op_a, op_b, flush,
                  output stall, done, hi, lo, mf_data);
endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// Radix-2 shift-add multiplier / restoring divider on magnitudes, with sign fixup of the result.
module muldiv_datapath #(parameter int unsigned WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic             signed_op,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last_step,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      count;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    a_neg = signed_op & op_a[WIDTH-1];
    b_neg = signed_op & op_b[WIDTH-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;

    // Multiplier sits in acc low half and is consumed LSB-first; the carry lands in the top bit.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Partial remainder needs WIDTH+1 bits after the shift; diff[WIDTH] is the borrow.
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opnd};
    div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

    prod_neg = -acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      count    <= '0;
      is_div   <= load_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= (op_b == '0);
      acc      <= {{WIDTH{1'b0}}, (load_div ? mag_a : mag_b)};
      opnd     <= load_div ? mag_b : mag_a;
    end else if (step_mul || step_div) begin
      count <= count + 1'b1;
      acc   <= step_mul ? mul_next : div_next;
    end
  end

  assign last_step = (count == CW'(WIDTH - 1));

  // A zero divisor leaves remainder = |op_a|, so the remainder sign fix restores op_a.
  always_comb begin
    if (is_div) begin
      res_lo = div_zero ? '1 : (neg_res ? -quo : quo);
      res_hi = neg_rem ? -rem : rem;
    end else begin
      res_lo = neg_res ? prod_neg[WIDTH-1:0]       : acc[WIDTH-1:0];
      res_hi = neg_res ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM sequencing the datapath, HI/LO registers, MT writes and MF read mux.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  state_t           state, state_next;
  logic             issue, load, step_mul, step_div, wr_result, last_step;
  logic [WIDTH-1:0] res_hi, res_lo, hi_q, lo_q;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_div  (is_div_op(bus.func)),
    .signed_op (is_signed_op(bus.func)),
    .step_mul  (step_mul),
    .step_div  (step_div),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .last_step (last_step),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  assign issue = (state == ST_IDLE) && bus.start && !bus.flush;

  always_comb begin
    state_next = state;
    bus.stall  = 1'b0;
    bus.done   = 1'b0;
    load       = 1'b0;
    step_mul   = 1'b0;
    step_div   = 1'b0;
    wr_result  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue && is_long_op(bus.func)) begin
          bus.stall  = 1'b1;
          load       = 1'b1;
          state_next = is_div_op(bus.func) ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        bus.stall = 1'b1;
        step_mul  = (state == ST_MUL);
        step_div  = (state == ST_DIV);
        if (bus.flush)      state_next = ST_IDLE;
        else if (last_step) state_next = ST_FIX;
      end
      ST_FIX: begin
        bus.stall = 1'b1;
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else begin
          wr_result  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_result) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (issue) begin
      if (bus.func == FN_MTHI) hi_q <= bus.op_a;
      if (bus.func == FN_MTLO) lo_q <= bus.op_a;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = (bus.func == FN_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: reset, MT/MF, mul/div results and latency, flush behaviour.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a long op in C0, scrambles inputs afterwards, checks stall C0..C33 and results in C34.
  task automatic run_long(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall_cnt = 0;
    int done_cnt  = 0;
    bus.func  = f;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(negedge clk);
    check({tag, "_c0_stall"}, bus.stall, 1);
    next_cycle();
    bus.start = 1'b0;
    bus.func  = FN_MFLO;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      stall_cnt += int'(bus.stall);
      done_cnt  += int'(bus.done);
      next_cycle();
    end
    check({tag, "_stall_c1_c33"}, stall_cnt, 33);
    check({tag, "_early_done"}, done_cnt, 0);
    @(negedge clk);
    check({tag, "_c34_done"}, bus.done, 1);
    check({tag, "_c34_stall"}, bus.stall, 0);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_mflo"}, bus.mf_data, exp_lo);
    next_cycle();
    @(negedge clk);
    check({tag, "_done_pulse"}, bus.done, 0);
    next_cycle();
  endtask

  initial begin
    int stall_cnt;
    int done_cnt;
    bus.start = 1'b0;
    bus.func  = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.flush = 1'b0;
    reset     = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    next_cycle();

    // Reset in the middle of a multiply
    bus.func  = FN_MTHI;
    bus.op_a  = 32'h0000_00AA;
    bus.start = 1'b1;
    next_cycle();
    bus.func  = FN_MULTU;
    bus.op_a  = 32'd9;
    bus.op_b  = 32'd9;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    check("midrst_stall", bus.stall, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_state", dut.state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    run_long("after_rst_multu", FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    run_long("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_long("mult_neg3x7", FN_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_long("mult_minsq", FN_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_long("div_neg7by2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long("divu_5by0", FN_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_long("div_min_by_m1", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_long("divu_100by7", FN_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Flush at C10 of a DIV with HI/LO preloaded
    bus.start = 1'b1;
    bus.func  = FN_MTHI;
    bus.op_a  = 32'h0000_00AA;
    next_cycle();
    bus.func  = FN_MTLO;
    bus.op_a  = 32'h0000_00BB;
    next_cycle();
    bus.func  = FN_DIV;
    bus.op_a  = 32'd1000;
    bus.op_b  = 32'd3;
    next_cycle();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) next_cycle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_c10_stall", bus.stall, 1);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_c11_stall", bus.stall, 0);
    stall_cnt = 0;
    done_cnt  = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      @(negedge clk);
      stall_cnt += int'(bus.stall);
      done_cnt  += int'(bus.done);
    end
    check("flush_no_stall", stall_cnt, 0);
    check("flush_no_done", done_cnt, 0);
    check("flush_hi_kept", bus.hi, 32'h0000_00AA);
    check("flush_lo_kept", bus.lo, 32'h0000_00BB);
    next_cycle();

    // start together with flush in IDLE: nothing happens
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.func  = FN_MTHI;
    bus.op_a  = 32'h0000_0055;
    @(negedge clk);
    check("sf_mthi_stall", bus.stall, 0);
    next_cycle();
    bus.func = FN_DIVU;
    @(negedge clk);
    check("sf_div_stall", bus.stall, 0);
    next_cycle();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("sf_stall_after", bus.stall, 0);
    check("sf_hi_kept", bus.hi, 32'h0000_00AA);
    check("sf_lo_kept", bus.lo, 32'h0000_00BB);
    next_cycle();

    // MTHI then MFHI
    bus.start = 1'b1;
    bus.func  = FN_MTHI;
    bus.op_a  = 32'h0000_1234;
    @(negedge clk);
    check("mthi_stall", bus.stall, 0);
    next_cycle();
    bus.func = FN_MFHI;
    bus.op_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mfhi_data", bus.mf_data, 32'h0000_1234);
    check("mfhi_stall", bus.stall, 0);
    next_cycle();
    bus.start = 1'b0;
    bus.func  = FN_MFLO;
    @(negedge clk);
    check("mflo_data", bus.mf_data, 32'h0000_00BB);
    next_cycle();

    run_long("multu_6x7", FN_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
